// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state enum and counter sizing for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// rtl/wb_lsu_if.sv - core request/response and Wishbone master signals of the load/store unit
interface wb_lsu_if #(
  parameter int XLEN = 32,
  parameter int AW   = 30
);

  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_we;
  logic [1:0]      i_req_size;
  logic            i_req_unsigned;
  logic [XLEN-1:0] i_req_addr;
  logic [XLEN-1:0] i_req_data;

  logic            o_rsp_valid;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_rsp_err;

  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [XLEN-1:0] o_wb_data;
  logic [3:0]      o_wb_sel;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic            i_wb_err;
  logic [XLEN-1:0] i_wb_data;

  // master: the load/store unit itself
  modport master (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

  // slave: the core plus the memory slave surrounding the unit
  modport slave (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane selects, store replication, load extraction/extension, alignment check
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]    size_i,
  input  logic [1:0]    off_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] rdata_i,
  input  logic          unsigned_i,
  output logic [3:0]    sel_o,
  output logic [DW-1:0] wdata_o,
  output logic [DW-1:0] rdata_o,
  output logic          misaligned_o
);

  logic [DW-1:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {off_i, 3'b000};
    sel_o        = 4'b0000;
    wdata_o      = '0;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        sel_o   = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        sel_o        = 4'b0011 << off_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = off_i[0];
      end
      SZ_W: begin
        sel_o        = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = shifted;
        misaligned_o = (off_i != 2'b00);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_lsu.sv
// rtl/wb_lsu.sv - load/store unit: one pipelined-Wishbone transaction per core request
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 30,
  parameter int TIMEOUT = 15
) (
  input logic       i_clk,
  input logic       i_reset,
  wb_lsu_if.master  bus
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            idle;
  logic [1:0]      al_size, al_off;
  logic            al_uns, al_mis;
  logic [XLEN-1:0] al_wdata_in, al_wdata, al_rdata;
  logic [3:0]      al_sel;

  // While idle the aligner judges the incoming request; afterwards it works on the latched one.
  assign idle        = (state_q == ST_IDLE);
  assign al_size     = idle ? bus.i_req_size : size_q;
  assign al_off      = idle ? bus.i_req_addr[1:0] : off_q;
  assign al_uns      = idle ? bus.i_req_unsigned : uns_q;
  assign al_wdata_in = idle ? bus.i_req_data : data_q;
  assign cnt_inc     = cnt_q + CW'(1);

  lsu_align u_align (
    .size_i       (al_size),
    .off_i        (al_off),
    .wdata_i      (al_wdata_in),
    .rdata_i      (bus.i_wb_data),
    .unsigned_i   (al_uns),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          we_d    = bus.i_req_we;
          size_d  = bus.i_req_size;
          uns_d   = bus.i_req_unsigned;
          off_d   = bus.i_req_addr[1:0];
          addr_d  = bus.i_req_addr[AW+1:2];
          data_d  = bus.i_req_data;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = al_mis;
          state_d = al_mis ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = cnt_inc;
        // Error beats ack; a completion always beats the timeout.
        if (bus.i_wb_ack || bus.i_wb_err) begin
          state_d = ST_RESP;
          err_d   = bus.i_wb_err;
          if (!we_q && !bus.i_wb_err) rdata_d = al_rdata;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else if (state_q == ST_REQ && !bus.i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_req_ready = idle && !i_reset;
  assign bus.o_wb_cyc    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign bus.o_wb_stb    = (state_q == ST_REQ);
  assign bus.o_wb_we     = bus.o_wb_cyc && we_q;
  assign bus.o_wb_addr   = bus.o_wb_cyc ? addr_q : '0;
  assign bus.o_wb_data   = bus.o_wb_cyc ? al_wdata : '0;
  assign bus.o_wb_sel    = bus.o_wb_cyc ? al_sel : 4'b0000;
  assign bus.o_rsp_valid = (state_q == ST_RESP);
  assign bus.o_rsp_data  = bus.o_rsp_valid ? rdata_q : '0;
  assign bus.o_rsp_err   = bus.o_rsp_valid && err_q;

endmodule

// File: tb/tb_wb_lsu.sv
// tb/tb_wb_lsu.sv - directed bench for wb_lsu against a small Wishbone memory model
module tb_wb_lsu;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  wb_lsu_if #(.XLEN(32), .AW(30)) bus ();
  wb_lsu_if #(.XLEN(32), .AW(30)) bus_to ();

  wb_lsu #(.XLEN(32), .AW(30), .TIMEOUT(15)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  wb_lsu #(.XLEN(32), .AW(30), .TIMEOUT(4)) dut_to (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus_to)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory slave: one-cycle registered ack, programmable stall, error and silent modes
  logic [31:0] mem [0:63];
  int          stall_req = 0;
  int          stall_cnt = 0;
  logic        err_mode = 1'b0;
  logic        no_ack = 1'b0;
  logic [5:0]  idx;

  assign idx = bus.o_wb_addr[5:0];
  assign bus.i_wb_stall = bus.o_wb_stb && (stall_cnt < stall_req);

  always @(posedge i_clk) begin
    bus.i_wb_ack <= 1'b0;
    bus.i_wb_err <= 1'b0;
    if (bus.o_wb_cyc && bus.o_wb_stb) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall && !no_ack) begin
      if (err_mode) begin
        bus.i_wb_err <= 1'b1;
      end else begin
        bus.i_wb_ack  <= 1'b1;
        bus.i_wb_data <= mem[idx];
        if (bus.o_wb_we)
          for (int b = 0; b < 4; b++)
            if (bus.o_wb_sel[b]) mem[idx][8*b +: 8] <= bus.o_wb_data[8*b +: 8];
      end
    end
  end

  assign bus_to.i_wb_stall = 1'b0;
  assign bus_to.i_wb_ack   = 1'b0;
  assign bus_to.i_wb_err   = 1'b0;
  assign bus_to.i_wb_data  = 32'h0;

  int          r_lat;
  logic        r_err, r_cyc, r_stable, r_we;
  logic [31:0] r_data, r_wdata;
  logic [29:0] r_addr;
  logic [3:0]  r_sel;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data);
    int   k;
    logic first;
    @(negedge i_clk);
    bus.i_req_we       = we;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_addr     = addr;
    bus.i_req_data     = data;
    bus.i_req_valid    = 1'b1;
    k = 0;
    while (!bus.o_req_ready && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    if (!bus.o_req_ready) check("ready_wait", 32'(bus.o_req_ready), 32'd1);
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    r_lat = -1; r_cyc = 1'b0; r_stable = 1'b1; first = 1'b1;
    r_err = 1'b0; r_data = 32'h0;
    r_addr = '0; r_sel = '0; r_wdata = '0; r_we = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge i_clk);
      if (bus.o_wb_cyc) r_cyc = 1'b1;
      if (bus.o_wb_stb) begin
        if (first) begin
          r_addr = bus.o_wb_addr; r_sel = bus.o_wb_sel;
          r_wdata = bus.o_wb_data; r_we = bus.o_wb_we;
          first = 1'b0;
        end else if (r_addr !== bus.o_wb_addr || r_sel !== bus.o_wb_sel ||
                     r_wdata !== bus.o_wb_data || r_we !== bus.o_wb_we) begin
          r_stable = 1'b0;
        end
      end
      if (bus.o_rsp_valid) begin
        r_lat  = n;
        r_err  = bus.o_rsp_err;
        r_data = bus.o_rsp_data;
        break;
      end
    end
    if (r_lat < 0) check("rsp_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic seen;

  initial begin
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_size = 2'd0;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = '0; bus.i_req_data = '0;
    bus_to.i_req_valid = 1'b0; bus_to.i_req_we = 1'b0; bus_to.i_req_size = 2'd0;
    bus_to.i_req_unsigned = 1'b0; bus_to.i_req_addr = '0; bus_to.i_req_data = '0;

    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(bus.o_req_ready), 32'd0);
    check("rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    check("rst_stb", 32'(bus.o_wb_stb), 32'd0);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_sel", 32'(bus.o_wb_sel), 32'd0);
    check("rst_rsp_data", bus.o_rsp_data, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("post_rst_ready", 32'(bus.o_req_ready), 32'd1);

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    check("sw_addr", 32'(r_addr), 32'h40);
    check("sw_sel", 32'(r_sel), 32'hF);
    check("sw_we", 32'(r_we), 32'd1);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_lat", 32'(r_lat), 32'd3);
    check("sw_err", 32'(r_err), 32'd0);
    check("sw_rdata", r_data, 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_lat", 32'(r_lat), 32'd3);
    check("lw_we", 32'(r_we), 32'd0);

    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5);
    check("sb_wdata", r_wdata, 32'hA5A5A5A5);
    check("sb_sel", 32'(r_sel), 32'h8);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    check("lb_data", r_data, 32'hFFFFFFA5);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    check("lbu_data", r_data, 32'h000000A5);
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    check("lb0_data", r_data, 32'hFFFFFFEF);

    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001);
    check("sh_sel", 32'(r_sel), 32'hC);
    check("sh_wdata", r_wdata, 32'h80018001);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    check("lh_data", r_data, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    check("lhu_data", r_data, 32'h00008001);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("lw_merged", r_data, 32'h8001BEEF);

    do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    check("lw_mis_err", 32'(r_err), 32'd1);
    check("lw_mis_lat", 32'(r_lat), 32'd1);
    check("lw_mis_cyc", 32'(r_cyc), 32'd0);
    check("lw_mis_data", r_data, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
    check("lh_mis_err", 32'(r_err), 32'd1);
    check("lh_mis_cyc", 32'(r_cyc), 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 32'h100, 32'h0);
    check("sz3_err", 32'(r_err), 32'd1);
    check("sz3_lat", 32'(r_lat), 32'd1);
    check("sz3_cyc", 32'(r_cyc), 32'd0);

    stall_req = 3;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    stall_req = 0;
    check("stall_lat", 32'(r_lat), 32'd6);
    check("stall_stable", 32'(r_stable), 32'd1);
    check("stall_data", r_data, 32'h8001BEEF);
    check("stall_err", 32'(r_err), 32'd0);

    err_mode = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    err_mode = 1'b0;
    check("buserr_err", 32'(r_err), 32'd1);
    check("buserr_data", r_data, 32'd0);
    check("buserr_lat", 32'(r_lat), 32'd3);

    // timeout instance: the slave on bus_to never answers
    @(negedge i_clk);
    bus_to.i_req_we = 1'b0; bus_to.i_req_size = 2'd2; bus_to.i_req_addr = 32'h100;
    bus_to.i_req_valid = 1'b1;
    @(posedge i_clk);
    #1 bus_to.i_req_valid = 1'b0;
    r_lat = -1; r_err = 1'b0; r_cyc = 1'b1; r_data = 32'h0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge i_clk);
      if (bus_to.o_rsp_valid) begin
        r_lat = n; r_err = bus_to.o_rsp_err; r_cyc = bus_to.o_wb_cyc; r_data = bus_to.o_rsp_data;
        break;
      end
    end
    check("to_lat_bound", 32'(r_lat >= 1 && r_lat <= 6), 32'd1);
    check("to_err", 32'(r_err), 32'd1);
    check("to_cyc", 32'(r_cyc), 32'd0);
    check("to_data", r_data, 32'd0);
    @(negedge i_clk);
    check("to_ready", 32'(bus_to.o_req_ready), 32'd1);

    // reset while waiting for an ack that never comes
    no_ack = 1'b1;
    @(negedge i_clk);
    bus.i_req_we = 1'b0; bus.i_req_size = 2'd2; bus.i_req_addr = 32'h100;
    bus.i_req_valid = 1'b1;
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
    check("wait_stb", 32'(bus.o_wb_stb), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midrst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    check("midrst_rsp", 32'(bus.o_rsp_valid), 32'd0);
    check("midrst_ready", 32'(bus.o_req_ready), 32'd0);
    i_reset = 1'b0;
    no_ack = 1'b0;
    seen = 1'b0;
    @(negedge i_clk);
    check("rel_ready", 32'(bus.o_req_ready), 32'd1);
    repeat (3) begin
      if (bus.o_rsp_valid) seen = 1'b1;
      @(negedge i_clk);
    end
    check("rel_no_rsp", 32'(seen), 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("recover_data", r_data, 32'h8001BEEF);
    check("recover_lat", 32'(r_lat), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
